tick_delay_timer: RTL and testbench

TICK_DELAY_TIMER -- requirements
Module: tick_delay_timer

---
 rtl/tick_delay_timer.sv | 155 +++++++++++++++
 tb/tb_tick_delay_timer.sv | 264 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/tick_delay_timer.sv
// Tick-driven delay timer: counts load_val selected ticks, then pulses done.
// Define TICK_WDOG_EN to build in the tick-loss watchdog (tick_fault).
module tick_delay_timer #(
    parameter int CNT_W    = 16,
    parameter int WDOG_LIM = 60000000
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             tick_1us,
    input  logic             tick_1ms,
    input  logic             tick_1s,
    input  logic [1:0]       sel,
    input  logic [CNT_W-1:0] load_val,
    input  logic             start,
    input  logic             abort,
    output logic             busy,
    output logic             done,
    output logic [CNT_W-1:0] remaining,
    output logic             tick_fault,
    output logic [1:0]       state_dbg
);

    // Handshake: start is a level request, accepted only in IDLE with abort low;
    // there is no ready output, so a start seen in RUN or DONE is dropped.
    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [1:0]       sel_q, sel_d;
    logic [CNT_W-1:0] rem_q, rem_d;
    logic             busy_q, done_q;
    logic             tick_sel;

    if (WDOG_LIM < 1) begin : g_bad_lim
        $error("WDOG_LIM must be at least 1");
    end

    always_comb begin
        case (sel_q)
            2'd0:    tick_sel = tick_1us;
            2'd1:    tick_sel = tick_1ms;
            2'd2:    tick_sel = tick_1s;
            default: tick_sel = 1'b1;
        endcase
    end

`ifdef TICK_WDOG_EN
    logic [31:0] wdog_q, wdog_d;
    logic        fault_q, fault_d;
    logic        wdog_expire;

    // Fires on the WDOG_LIM-th consecutive tickless cycle in RUN.
    assign wdog_expire = (wdog_q == 32'(WDOG_LIM - 1));
`endif

    always_comb begin
        state_d = state_q;
        sel_d   = sel_q;
        rem_d   = rem_q;
`ifdef TICK_WDOG_EN
        wdog_d  = wdog_q;
        fault_d = fault_q;
`endif
        case (state_q)
            S_IDLE: begin
                if (start && !abort) begin
                    sel_d = sel;
`ifdef TICK_WDOG_EN
                    wdog_d  = '0;
                    fault_d = 1'b0;
`endif
                    if (load_val == '0) begin
                        state_d = S_DONE;
                        rem_d   = '0;
                    end else begin
                        state_d = S_RUN;
                        rem_d   = load_val;
                    end
                end
            end
            S_RUN: begin
                if (abort) begin
                    state_d = S_IDLE;
                    rem_d   = '0;
                end else if (tick_sel) begin
                    rem_d = rem_q - 1'b1;
`ifdef TICK_WDOG_EN
                    wdog_d = '0;
`endif
                    if (rem_q == CNT_W'(1)) begin
                        state_d = S_DONE;
                    end
                end
`ifdef TICK_WDOG_EN
                else if (sel_q != 2'd3) begin
                    if (wdog_expire) begin
                        state_d = S_IDLE;
                        rem_d   = '0;
                        wdog_d  = '0;
                        fault_d = 1'b1;
                    end else begin
                        wdog_d = wdog_q + 32'd1;
                    end
                end
`endif
            end
            S_DONE: begin
                state_d = S_IDLE;
                rem_d   = '0;
            end
            default: begin
                state_d = S_IDLE;
                rem_d   = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_IDLE;
            sel_q   <= 2'd0;
            rem_q   <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
`ifdef TICK_WDOG_EN
            wdog_q  <= '0;
            fault_q <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            sel_q   <= sel_d;
            rem_q   <= rem_d;
            busy_q  <= (state_d != S_IDLE);
            done_q  <= (state_d == S_DONE);
`ifdef TICK_WDOG_EN
            wdog_q  <= wdog_d;
            fault_q <= fault_d;
`endif
        end
    end

    assign busy      = busy_q;
    assign done      = done_q;
    assign remaining = rem_q;
    assign state_dbg = state_q;
`ifdef TICK_WDOG_EN
    assign tick_fault = fault_q;
`else
    assign tick_fault = 1'b0;
`endif

endmodule

// File: tb/tb_tick_delay_timer.sv
// Bench for tick_delay_timer: directed scenarios, literal pins and a per-cycle reference model.
module tb_tick_delay_timer;
    localparam int CNT_W    = 16;
    localparam int WDOG_LIM = 100;
`ifdef TICK_WDOG_EN
    localparam bit WDOG_EN = 1'b1;
`else
    localparam bit WDOG_EN = 1'b0;
`endif

    logic             clk = 1'b0;
    logic             reset;
    logic             tick_1us, tick_1ms, tick_1s;
    logic [1:0]       sel;
    logic [CNT_W-1:0] load_val;
    logic             start, abort;
    logic             busy, done, tick_fault;
    logic [CNT_W-1:0] remaining;
    logic [1:0]       state_dbg;

    int checks   = 0;
    int failures = 0;
    bit chk_en   = 1'b0;

    tick_delay_timer #(.CNT_W(CNT_W), .WDOG_LIM(WDOG_LIM)) dut (
        .clk(clk), .reset(reset),
        .tick_1us(tick_1us), .tick_1ms(tick_1ms), .tick_1s(tick_1s),
        .sel(sel), .load_val(load_val), .start(start), .abort(abort),
        .busy(busy), .done(done), .remaining(remaining),
        .tick_fault(tick_fault), .state_dbg(state_dbg)
    );

    // clock / reset
    always #5 clk = ~clk;

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d at t=%0t", name, act, exp, $time);
        end
    endtask

    // reference model: a delay is "armed" with a tick budget, or "finishing" for one cycle
    bit        m_run, m_fin, m_fault;
    int        m_left, m_wd;
    logic [1:0] m_sel;

    function automatic bit sel_tick(input logic [1:0] s);
        case (s)
            2'd0:    return tick_1us;
            2'd1:    return tick_1ms;
            2'd2:    return tick_1s;
            default: return 1'b1;
        endcase
    endfunction

    always @(posedge clk) begin
        if (reset) begin
            m_run = 0; m_fin = 0; m_fault = 0; m_left = 0; m_wd = 0; m_sel = 2'd0;
        end else if (m_fin) begin
            m_fin = 0;
        end else if (m_run) begin
            if (abort) begin
                m_run = 0; m_left = 0;
            end else if (sel_tick(m_sel)) begin
                m_left = m_left - 1;
                m_wd = 0;
                if (m_left == 0) begin m_run = 0; m_fin = 1; end
            end else if (WDOG_EN && m_sel != 2'd3) begin
                m_wd = m_wd + 1;
                if (m_wd >= WDOG_LIM) begin m_fault = 1; m_run = 0; m_left = 0; end
            end
        end else if (start && !abort) begin
            m_sel = sel; m_fault = 0; m_wd = 0;
            if (load_val == '0) m_fin = 1;
            else begin m_run = 1; m_left = int'(load_val); end
        end
    end

    // per-cycle compare
    always @(negedge clk) begin
        if (chk_en) begin
            chk("busy", 32'(busy), 32'(m_run | m_fin));
            chk("done", 32'(done), 32'(m_fin));
            chk("remaining", 32'(remaining), 32'(m_left));
            chk("tick_fault", 32'(tick_fault), 32'(m_fault));
        end
    end

    int t1_rem[7]  = '{5, 4, 3, 2, 1, 0, 0};
    int t1_busy[7] = '{1, 1, 1, 1, 1, 1, 0};
    int t1_done[7] = '{0, 0, 0, 0, 0, 1, 0};
    int vec_sel[4]  = '{0, 1, 2, 3};
    int vec_load[4] = '{2, 3, 1, 4};

    initial begin
        int done_cyc, done_cnt, fault_cyc;
        bit seen_run, finished;

        reset = 1; tick_1us = 0; tick_1ms = 0; tick_1s = 0;
        sel = 0; load_val = 0; start = 0; abort = 0;
        cyc(); cyc(); cyc();
        chk("rst_busy", 32'(busy), 0);
        chk("rst_done", 32'(done), 0);
        chk("rst_remaining", 32'(remaining), 0);
        chk("rst_fault", 32'(tick_fault), 0);
        reset = 0;
        chk_en = 1;
        cyc();

        // sel=3, load 5; later start and sel/load changes must be ignored
        sel = 2'd3; load_val = 16'd5; start = 1;
        cyc();
        start = 0; sel = 2'd0; load_val = 16'd9;
        for (int k = 0; k < 7; k++) begin
            chk("t1_rem", 32'(remaining), 32'(t1_rem[k]));
            chk("t1_busy", 32'(busy), 32'(t1_busy[k]));
            chk("t1_done", 32'(done), 32'(t1_done[k]));
            start = (k == 2);
            cyc();
        end
        start = 0;
        cyc();

        // sel=1, load 3, tick_1ms every 50 clk, first tick coincident with start
        done_cyc = -1; done_cnt = 0;
        for (int i = 0; i < 170; i++) begin
            tick_1ms = (i % 50 == 0);
            start = (i == 0);
            sel = (i == 0) ? 2'd1 : 2'd2;
            load_val = (i == 0) ? 16'd3 : 16'd1;
            cyc();
            if (done) begin done_cnt++; done_cyc = i + 1; end
        end
        tick_1ms = 0; start = 0;
        chk("t2_done_cycle", 32'(done_cyc), 151);
        chk("t2_done_count", 32'(done_cnt), 1);

        // load 0: straight to DONE, RUN never visited
        sel = 2'd0; load_val = 16'd0; start = 1;
        seen_run = 0;
        cyc();
        start = 0;
        chk("t3_done", 32'(done), 1);
        chk("t3_state_done", 32'(state_dbg), 2);
        chk("t3_remaining", 32'(remaining), 0);
        for (int k = 0; k < 3; k++) begin
            if (state_dbg == 2'd1) seen_run = 1;
            cyc();
        end
        chk("t3_no_run", 32'(seen_run), 0);
        chk("t3_idle_done", 32'(done), 0);

        // abort in RUN with remaining=4, then start+abort in IDLE
        sel = 2'd0; load_val = 16'd4; start = 1;
        cyc();
        start = 0;
        cyc(); cyc();
        chk("t4_rem_before", 32'(remaining), 4);
        abort = 1;
        cyc();
        abort = 0;
        chk("t4_busy", 32'(busy), 0);
        chk("t4_remaining", 32'(remaining), 0);
        chk("t4_done", 32'(done), 0);
        start = 1; abort = 1; load_val = 16'd6;
        cyc();
        start = 0; abort = 0;
        chk("t4_sa_busy", 32'(busy), 0);
        chk("t4_sa_state", 32'(state_dbg), 0);
        cyc();

        // reset in RUN with remaining=7, then a normal delay
        sel = 2'd2; load_val = 16'd7; start = 1;
        cyc();
        start = 0;
        chk("t5_rem_before", 32'(remaining), 7);
        reset = 1; start = 1; abort = 1; tick_1s = 1;
        cyc();
        reset = 0; start = 0; abort = 0; tick_1s = 0;
        chk("t5_busy", 32'(busy), 0);
        chk("t5_done", 32'(done), 0);
        chk("t5_remaining", 32'(remaining), 0);
        chk("t5_fault", 32'(tick_fault), 0);
        sel = 2'd3; load_val = 16'd2; start = 1;
        cyc();
        start = 0;
        chk("t5_after_rem", 32'(remaining), 2);
        cyc();
        chk("t5_after_rem1", 32'(remaining), 1);
        cyc();
        chk("t5_after_done", 32'(done), 1);
        cyc();

        // tick loss on sel=0 with no tick_1us
        sel = 2'd0; load_val = 16'd3; start = 1;
        cyc();
        start = 0;
        fault_cyc = -1; done_cnt = 0;
        for (int i = 1; i <= 120; i++) begin
            if (tick_fault && fault_cyc < 0) fault_cyc = i;
            if (done) done_cnt++;
            cyc();
        end
`ifdef TICK_WDOG_EN
        chk("t6_fault_cycle", 32'(fault_cyc), 101);
        chk("t6_busy", 32'(busy), 0);
        chk("t6_no_done", 32'(done_cnt), 0);
        sel = 2'd3; load_val = 16'd150; start = 1;
        cyc();
        start = 0;
        chk("t6_fault_cleared", 32'(tick_fault), 0);
        for (int i = 0; i < 155; i++) cyc();
        chk("t6_sel3_nofault", 32'(tick_fault), 0);
`else
        chk("t6_fault_cycle", 32'(fault_cyc), 32'hFFFF_FFFF);
        chk("t6_still_busy", 32'(busy), 1);
        chk("t6_rem_held", 32'(remaining), 3);
        abort = 1;
        cyc();
        abort = 0;
        chk("t6_aborted", 32'(busy), 0);
`endif
        cyc();

        // directed vectors against free-running tick patterns
        for (int v = 0; v < 4; v++) begin
            int i;
            finished = 0;
            sel = 2'(vec_sel[v]); load_val = 16'(vec_load[v]); start = 1;
            i = 0;
            while (!finished && i < 100) begin
                tick_1us = (i % 3 == 1);
                tick_1ms = (i % 7 == 2);
                tick_1s  = (i % 11 == 5);
                cyc();
                start = (i % 4 == 3);
                sel = 2'((i + v) % 4);
                load_val = 16'(i);
                if (!busy && i > 0) finished = 1;
                i++;
            end
            start = 0; tick_1us = 0; tick_1ms = 0; tick_1s = 0;
            chk("vec_finished", 32'(finished), 1);
            cyc(); cyc();
        end

        chk_en = 0;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL timeout: simulation did not finish, got running expected finished");
        $fatal(1, "timeout");
    end
endmodule
